spi_load_arbiter: RTL and testbench

SPI_LOAD_ARBITER -- requirements
Module: spi_load_arbiter

---
 rtl/spi_pkg.sv | 7 +
 rtl/rr_arb2.sv | 16 +
 rtl/spi_load_arbiter.sv | 121 ++++++++++++
 tb/tb_spi_load_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared defaults and FSM state type for the SPI load arbiter.
package spi_pkg;
    localparam int SPI_DATA_WIDTH = 8;
    localparam int SPI_MAX_BURST  = 20;
    localparam int SPI_TIMEOUT    = 64;
    typedef enum logic [1:0] {IDLE, LOAD, WAIT_START, WAIT_END} spi_arb_state_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin picker; rr names the requester favoured on a tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       nrst,
    input  logic [1:0] req_i,
    input  logic       adv_i,
    input  logic       own0_i,
    output logic [1:0] pick_o
);
    logic rr_q;
    // After a burst the pointer moves to the requester that did not own it.
    always_ff @(posedge clk or negedge nrst)
        if (!nrst) rr_q <= 1'b0;
        else if (adv_i) rr_q <= own0_i;
    always_comb pick_o = (&req_i) ? (rr_q ? 2'b10 : 2'b01) : req_i;
endmodule

// File: rtl/spi_load_arbiter.sv
// spi_load_arbiter: merges two byte requesters into bursts for a host BYTE_STORE,
// then waits for the host to transmit (host_sel low, then high) before rearbitrating.
module spi_load_arbiter
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = SPI_DATA_WIDTH,
    parameter int MAX_BURST  = SPI_MAX_BURST,
    parameter int TIMEOUT    = SPI_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  rq0_valid,
    input  logic [DATA_WIDTH-1:0] rq0_data,
    input  logic                  rq0_last,
    output logic                  rq0_ready,
    input  logic                  rq1_valid,
    input  logic [DATA_WIDTH-1:0] rq1_data,
    input  logic                  rq1_last,
    output logic                  rq1_ready,
    output logic                  load_iv,
    output logic [DATA_WIDTH-1:0] load_id,
    input  logic                  host_sel,
    output logic [1:0]            grant,
    output logic                  err
);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    spi_arb_state_t        state_q, state_d;
    logic [1:0]            grant_q, grant_d, pick;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [TW-1:0]         tcnt_q, tcnt_d;
    logic                  iv_q, err_q, err_d, arm_q;
    logic [DATA_WIDTH-1:0] id_q, id_d;
    logic                  rdy, sel_v, sel_l, acc, burst_end;
    logic [DATA_WIDTH-1:0] sel_data;

    assign sel_v     = grant_q[1] ? rq1_valid : rq0_valid;
    assign sel_l     = grant_q[1] ? rq1_last : rq0_last;
    assign sel_data  = grant_q[1] ? rq1_data : rq0_data;
    assign rdy       = (state_q == LOAD) && (cnt_q < CW'(MAX_BURST));
    assign rq0_ready = grant_q[0] & rdy;
    assign rq1_ready = grant_q[1] & rdy;
    assign acc       = sel_v & rdy;
    // A valid gap ends the burst without consuming last; the rest goes in a later burst.
    assign burst_end = (state_q == LOAD) &&
                       (!sel_v || (acc && (sel_l || cnt_q == CW'(MAX_BURST - 1))));

    assign load_iv = iv_q;
    assign load_id = id_q;
    assign grant   = grant_q;
    assign err     = err_q;

    rr_arb2 u_rr (
        .clk    (clk),
        .nrst   (nrst),
        .req_i  ({rq1_valid, rq0_valid}),
        .adv_i  (burst_end),
        .own0_i (grant_q[0]),
        .pick_o (pick)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        tcnt_d  = tcnt_q;
        id_d    = acc ? sel_data : id_q;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: if (arm_q && |pick) begin
                state_d = LOAD;
                grant_d = pick;
                cnt_d   = '0;
            end
            LOAD: begin
                cnt_d = acc ? cnt_q + 1'b1 : cnt_q;
                if (burst_end) begin
                    state_d = WAIT_START;
                    tcnt_d  = '0;
                end
            end
            WAIT_START: begin
                tcnt_d = tcnt_q + 1'b1;
                if (!host_sel) state_d = WAIT_END;
                else if (tcnt_d == TW'(TIMEOUT)) begin
                    state_d = IDLE;
                    grant_d = '0;
                    err_d   = 1'b1;
                end
            end
            WAIT_END: if (host_sel) begin
                state_d = IDLE;
                grant_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // arm_q delays the first arbitration to the second edge after reset release.
    always_ff @(posedge clk or negedge nrst)
        if (!nrst) begin
            state_q <= IDLE;
            grant_q <= '0;
            cnt_q   <= '0;
            tcnt_q  <= '0;
            iv_q    <= 1'b0;
            id_q    <= '0;
            err_q   <= 1'b0;
            arm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            tcnt_q  <= tcnt_d;
            iv_q    <= acc;
            id_q    <= id_d;
            err_q   <= err_d;
            arm_q   <= 1'b1;
        end
endmodule

// File: tb/tb_spi_load_arbiter.sv
// tb_spi_load_arbiter: directed and random bursts checked against per-requester byte
// streams, burst-length and last-boundary rules, host handshake and timeout timing.
module tb_spi_load_arbiter;
    localparam int MB = 20;
    localparam int TO = 64;

    typedef struct {
        logic [7:0] d;
        logic       l;
        int         gap;
    } ent_t;

    logic       clk = 1'b0, nrst = 1'b0, host_sel = 1'b1;
    logic       v [2] = '{1'b0, 1'b0};
    logic       ll[2] = '{1'b0, 1'b0};
    logic [7:0] dd[2] = '{8'h00, 8'h00};
    logic       rdy0, rdy1, load_iv, err;
    logic [7:0] load_id;
    logic [1:0] grant;

    ent_t dq[2][$];
    ent_t sq[2][$];
    bit   acc[2];
    int   lens[$], owns[$];
    int   blen = 0, bown = 0;
    bit   plast = 0, mon_en = 1, tmo_mode = 0, host_en = 1, host_rand = 0, served = 0;
    int   checks = 0, failures = 0;

    spi_load_arbiter dut (
        .clk(clk), .nrst(nrst),
        .rq0_valid(v[0]), .rq0_data(dd[0]), .rq0_last(ll[0]), .rq0_ready(rdy0),
        .rq1_valid(v[1]), .rq1_data(dd[1]), .rq1_last(ll[1]), .rq1_ready(rdy1),
        .load_iv(load_iv), .load_id(load_id), .host_sel(host_sel),
        .grant(grant), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int at(int q[$], int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic submit(int i, int n, logic [7:0] base, int gap_at, int gap);
        for (int j = 0; j < n; j++) begin
            ent_t e;
            e.d   = 8'(base + j);
            e.l   = (j == n - 1);
            e.gap = (j == gap_at) ? gap : 0;
            dq[i].push_back(e);
            sq[i].push_back(e);
        end
    endtask

    task automatic drain(string tag);
        int n = 0;
        while ((dq[0].size() + dq[1].size() + sq[0].size() + sq[1].size() != 0 ||
                grant != 2'b00 || blen != 0 || !host_sel) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, n < 20000, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        #1;
        chk("rst_load_iv", load_iv, 0);
        chk("rst_grant", grant, 0);
        chk("rst_ready", {rdy0, rdy1}, 0);
        chk("rst_err", err, 0);
        chk("rst_load_id", load_id, 0);
        for (int i = 0; i < 2; i++) begin
            dq[i].delete();
            sq[i].delete();
            acc[i] = 1'b0;
        end
        blen = 0; plast = 0; served = 0; host_sel = 1'b1;
        lens.delete(); owns.delete();
        repeat (2) @(negedge clk);
        nrst = 1'b1;
    endtask

    // requester drivers: present queued bytes, honour per-byte gaps, pop on acceptance
    initial begin : drv
        ent_t t;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (acc[i] && dq[i].size() > 0) void'(dq[i].pop_front());
                acc[i] = 1'b0;
                if (dq[i].size() == 0) v[i] = 1'b0;
                else if (dq[i][0].gap > 0) begin
                    t = dq[i][0];
                    t.gap--;
                    dq[i][0] = t;
                    v[i] = 1'b0;
                end else begin
                    v[i]  = 1'b1;
                    dd[i] = dq[i][0].d;
                    ll[i] = dq[i][0].l;
                end
            end
            #1;
            acc[0] = v[0] & rdy0;
            acc[1] = v[1] & rdy1;
        end
    end

    // scoreboard: each owner's load bytes must replay its submitted stream in order
    initial begin : mon
        ent_t e;
        int   o;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (load_iv) begin
                    o = int'(grant[1]);
                    chk("grant_onehot", grant == 2'b01 || grant == 2'b10, 1);
                    chk("after_last", plast, 0);
                    if (blen > 0) chk("burst_owner", o, bown);
                    bown = o;
                    chk("stream_has_byte", sq[o].size() > 0, 1);
                    if (sq[o].size() > 0) begin
                        e = sq[o].pop_front();
                        chk("load_id", load_id, e.d);
                        plast = e.l;
                    end
                    blen++;
                end else begin
                    if (blen > 0) begin
                        chk("burst_len_max", blen <= MB, 1);
                        lens.push_back(blen);
                        owns.push_back(bown);
                    end
                    blen = 0;
                    plast = 0;
                end
                if (!tmo_mode) chk("no_err", err, 0);
            end
        end
    end

    // host: after a burst (grant held, nobody ready) pull host_sel low for a while
    initial begin : host
        int d, k;
        forever begin
            @(negedge clk);
            if (grant == 2'b00) served = 0;
            else if (host_en && !served && !rdy0 && !rdy1) begin
                d = host_rand ? int'($urandom_range(0, 10)) : 2;
                k = host_rand ? int'($urandom_range(1, 8)) : 10;
                repeat (d) @(negedge clk);
                host_sel = 1'b0;
                repeat (k) @(negedge clk);
                host_sel = 1'b1;
                served = 1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (2) @(negedge clk);
        submit(0, 14, 8'h01, -1, 0);
        @(negedge clk);
        #1;
        chk("rst_hold_ready", rdy0, 0);
        chk("rst_hold_grant", grant, 0);
        chk("rst_hold_iv", load_iv, 0);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        chk("no_arb_first_edge", grant, 0);
        @(negedge clk);
        chk("arb_second_edge", grant, 1);
        drain("s1_drain");
        chk("s1_bursts", lens.size(), 1);
        chk("s1_len", at(lens, 0), 14);
        chk("s1_owner", at(owns, 0), 0);
        chk("s1_idle_grant", grant, 0);

        lens.delete(); owns.delete();
        submit(0, 25, 8'h01, -1, 0);
        drain("s2_drain");
        chk("s2_bursts", lens.size(), 2);
        chk("s2_len0", at(lens, 0), MB);
        chk("s2_len1", at(lens, 1), 5);

        @(negedge clk);
        #2;
        do_reset();
        submit(0, 3, 8'h30, -1, 0);
        submit(0, 3, 8'h40, -1, 0);
        submit(1, 3, 8'h50, -1, 0);
        drain("s3_drain");
        chk("s3_bursts", lens.size(), 3);
        chk("s3_own0", at(owns, 0), 0);
        chk("s3_own1", at(owns, 1), 1);
        chk("s3_own2", at(owns, 2), 0);

        host_en = 0;
        tmo_mode = 1;
        submit(0, 2, 8'h60, -1, 0);
        n = 0;
        while (!(grant != 2'b00 && !rdy0 && !rdy1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("s4_wait_start_seen", n < 200, 1);
        n = 0;
        while (!err && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("s4_timeout_cycles", n, TO);
        chk("s4_grant_cleared", grant, 0);
        @(negedge clk);
        chk("s4_err_one_cycle", err, 0);
        tmo_mode = 0;
        host_en = 1;
        drain("s4_drain");

        lens.delete(); owns.delete();
        submit(1, 10, 8'h70, 5, 3);
        drain("s5_drain");
        chk("s5_bursts", lens.size(), 2);
        chk("s5_len0", at(lens, 0), 5);
        chk("s5_len1", at(lens, 1), 5);
        chk("s5_own0", at(owns, 0), 1);
        chk("s5_own1", at(owns, 1), 1);

        submit(0, 14, 8'h80, -1, 0);
        n = 0;
        while (blen != 7 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("s6_reached_7", blen, 7);
        #1;
        chk("s6_pre_iv", load_iv, 1);
        do_reset();
        submit(0, 14, 8'h90, -1, 0);
        drain("s6_drain");
        chk("s6_bursts", lens.size(), 1);
        chk("s6_len", at(lens, 0), 14);
        chk("s6_owner", at(owns, 0), 0);

        host_rand = 1;
        lens.delete(); owns.delete();
        for (int m = 0; m < 6; m++)
            for (int i = 0; i < 2; i++) begin
                int len = int'($urandom_range(1, 30));
                submit(i, len, 8'($urandom), ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, len - 1)) : -1,
                       int'($urandom_range(1, 4)));
            end
        drain("rand_drain");
        chk("rand_bursts_seen", lens.size() > 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
